// File: rtl/wolfram_ca_engine_if.sv
// Control and observation bundle for the cellular-automaton engine.
// The bench drives it through master and the engine uses it through slave.
interface wolfram_ca_engine_if #(
    parameter int WIDTH = 16,
    parameter int GEN_W = 8
);
    logic             rule_load;
    logic [7:0]       rule_in;
    logic             state_load;
    logic [WIDTH-1:0] state_in;
    logic [1:0]       boundary_mode;
    logic             stop_on_stable;
    logic             start;
    logic [GEN_W-1:0] num_gens;
    logic             hold;
    logic [WIDTH-1:0] cells;
    logic [7:0]       rule;
    logic [GEN_W-1:0] gen_count;
    logic             busy;
    logic             done;
    logic             stable;

    modport master (
        output rule_load, rule_in, state_load, state_in, boundary_mode,
               stop_on_stable, start, num_gens, hold,
        input  cells, rule, gen_count, busy, done, stable
    );

    modport slave (
        input  rule_load, rule_in, state_load, state_in, boundary_mode,
               stop_on_stable, start, num_gens, hold,
        output cells, rule, gen_count, busy, done, stable
    );
endinterface

// File: rtl/wolfram_ca_engine.sv
// Programmable 1-D elementary cellular automaton.
// Steps every cell once per clock for a requested number of generations.
module wolfram_ca_cell (
    input  logic [2:0] nbr_i,
    input  logic [7:0] rule_i,
    output logic       nxt_o
);
    // The rule table is indexed MSB-first: pattern 3'b111 selects rule bit 0.
    assign nxt_o = rule_i[3'd7 - nbr_i];
endmodule

module wolfram_ca_engine #(
    parameter int         WIDTH        = 16,
    parameter int         GEN_W        = 8,
    parameter logic [7:0] RULE_DEFAULT = 8'h31
) (
    input  logic                clk,
    input  logic                rst,
    wolfram_ca_engine_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] cells_q, cells_d;
    logic [7:0]       rule_q, rule_d;
    logic [GEN_W-1:0] gen_q, gen_d;
    logic [GEN_W-1:0] ngens_q, ngens_d;
    logic [1:0]       bmode_q, bmode_d;
    logic             sos_q, sos_d;
    logic             stable_q, stable_d;

    logic             lb, rb;
    logic [WIDTH+1:0] ext;
    logic [WIDTH-1:0] next_cells;

    always_comb begin
        lb = 1'b0;
        rb = 1'b0;
        case (bmode_q)
            2'b00: begin
                lb = cells_q[0];
                rb = cells_q[WIDTH-1];
            end
            2'b10: begin
                lb = 1'b1;
                rb = 1'b1;
            end
            default: begin
                lb = 1'b0;
                rb = 1'b0;
            end
        endcase
    end

    // ext[i+2:i] is {left, self, right} for cell i.
    assign ext = {lb, cells_q, rb};

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        wolfram_ca_cell u_cell (
            .nbr_i  (ext[i+2:i]),
            .rule_i (rule_q),
            .nxt_o  (next_cells[i])
        );
    end

    always_comb begin
        state_d  = state_q;
        cells_d  = cells_q;
        rule_d   = rule_q;
        gen_d    = gen_q;
        ngens_d  = ngens_q;
        bmode_d  = bmode_q;
        sos_d    = sos_q;
        stable_d = stable_q;
        case (state_q)
            S_IDLE: begin
                if (bus.rule_load || bus.state_load) begin
                    if (bus.rule_load)  rule_d  = bus.rule_in;
                    if (bus.state_load) cells_d = bus.state_in;
                end else if (bus.start) begin
                    ngens_d  = bus.num_gens;
                    bmode_d  = bus.boundary_mode;
                    sos_d    = bus.stop_on_stable;
                    gen_d    = '0;
                    stable_d = 1'b0;
                    state_d  = (bus.num_gens != '0) ? S_RUN : S_DONE;
                end
            end
            S_RUN: begin
                if (!bus.hold) begin
                    cells_d  = next_cells;
                    gen_d    = gen_q + GEN_W'(1);
                    stable_d = (next_cells == cells_q);
                    if ((gen_d == ngens_q) || (sos_q && stable_d)) state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cells_q  <= '0;
            rule_q   <= RULE_DEFAULT;
            gen_q    <= '0;
            ngens_q  <= '0;
            bmode_q  <= 2'b00;
            sos_q    <= 1'b0;
            stable_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cells_q  <= cells_d;
            rule_q   <= rule_d;
            gen_q    <= gen_d;
            ngens_q  <= ngens_d;
            bmode_q  <= bmode_d;
            sos_q    <= sos_d;
            stable_q <= stable_d;
        end
    end

    assign bus.cells     = cells_q;
    assign bus.rule      = rule_q;
    assign bus.gen_count = gen_q;
    assign bus.stable    = stable_q;
    assign bus.busy      = (state_q == S_RUN);
    assign bus.done      = (state_q == S_DONE);
endmodule

// File: tb/tb_wolfram_ca_engine.sv
// Bench for the cellular-automaton engine: directed cases plus randomized runs
// scored against a generation-by-generation reference model.
module tb_wolfram_ca_engine;
    localparam int W = 8;
    localparam int G = 8;

    logic clk = 1'b0;
    logic rst;
    int   total  = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    wolfram_ca_engine_if #(.WIDTH(W), .GEN_W(G)) bus ();

    wolfram_ca_engine #(.WIDTH(W), .GEN_W(G), .RULE_DEFAULT(8'h31)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] model_next(input logic [W-1:0] c, input logic [7:0] r,
                                                input logic [1:0] m);
        logic [W-1:0] res;
        int edge_v, l, s, rr, p;
        edge_v = (m == 2'b10) ? 1 : 0;
        for (int i = 0; i < W; i++) begin
            s  = int'(c[i]);
            l  = (i == W-1) ? ((m == 2'b00) ? int'(c[0])   : edge_v) : int'(c[i+1]);
            rr = (i == 0)   ? ((m == 2'b00) ? int'(c[W-1]) : edge_v) : int'(c[i-1]);
            p  = 4*l + 2*s + rr;
            res[i] = r[7-p];
        end
        return res;
    endfunction

    task automatic do_load(input logic [7:0] r, input logic [W-1:0] s);
        bus.rule_load = 1'b1; bus.rule_in = r;
        bus.state_load = 1'b1; bus.state_in = s;
        cyc();
        bus.rule_load = 1'b0; bus.state_load = 1'b0;
    endtask

    task automatic do_start(input logic [G-1:0] n, input logic [1:0] m, input logic sos);
        bus.start = 1'b1; bus.num_gens = n; bus.boundary_mode = m; bus.stop_on_stable = sos;
        cyc();
        bus.start = 1'b0;
    endtask

    // Loads, starts, lets the run finish under optional random hold and scores every cycle.
    task automatic run_expect(input logic [7:0] r, input logic [W-1:0] init, input logic [1:0] m,
                              input logic sos, input int n, input logic hold_en);
        logic [W-1:0] gens [0:255];
        int eg, steps, cnt;
        logic est, h;
        gens[0] = init; eg = 0; est = 1'b0;
        while (eg < n) begin
            gens[eg+1] = model_next(gens[eg], r, m);
            eg++;
            est = (gens[eg] == gens[eg-1]);
            if (sos && est) break;
        end
        do_load(r, init);
        total++; if (bus.rule !== r) $display("FAIL rule_load got %h want %h", bus.rule, r); else passed++;
        do_start(G'(n), m, sos);
        steps = 0; cnt = 0;
        while (bus.busy && cnt < 400) begin
            h = hold_en ? ($urandom_range(0, 2) == 0) : 1'b0;
            bus.hold = h;
            cyc(); cnt++;
            if (!h) steps++;
            if (steps <= eg) begin
                total++;
                if (bus.cells !== gens[steps])
                    $display("FAIL step_cells gen %0d got %b want %b", steps, bus.cells, gens[steps]);
                else passed++;
            end
        end
        bus.hold = 1'b0;
        total++; if (cnt >= 400) $display("FAIL run_timeout cycles %0d limit 400", cnt); else passed++;
        total++; if (steps !== eg) $display("FAIL run_steps got %0d want %0d", steps, eg); else passed++;
        total++; if (bus.done !== 1'b1) $display("FAIL done_pulse got %b want 1", bus.done); else passed++;
        total++; if (bus.gen_count !== G'(eg)) $display("FAIL gen_count got %0d want %0d", bus.gen_count, eg); else passed++;
        total++; if (bus.stable !== est) $display("FAIL stable got %b want %b", bus.stable, est); else passed++;
        total++; if (bus.cells !== gens[eg]) $display("FAIL final_cells got %b want %b", bus.cells, gens[eg]); else passed++;
        cyc();
        total++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) $display("FAIL done_one_cycle done %b busy %b want 0 0", bus.done, bus.busy); else passed++;
        total++; if (bus.cells !== gens[eg]) $display("FAIL cells_hold_idle got %b want %b", bus.cells, gens[eg]); else passed++;
    endtask

    task automatic test_reset();
        rst = 1'b1; cyc(); cyc(); rst = 1'b0;
        total++; if (bus.cells !== '0) $display("FAIL reset_cells got %h want 00", bus.cells); else passed++;
        total++; if (bus.rule !== 8'h31) $display("FAIL reset_rule got %h want 31", bus.rule); else passed++;
        total++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) $display("FAIL reset_flags busy %b done %b want 0 0", bus.busy, bus.done); else passed++;
        total++; if (bus.gen_count !== '0 || bus.stable !== 1'b0) $display("FAIL reset_count gen %0d stable %b want 0 0", bus.gen_count, bus.stable); else passed++;
    endtask

    task automatic test_examples();
        do_load(8'h31, 8'b0000_0110);
        do_start(8'd1, 2'b00, 1'b0);
        total++; if (bus.busy !== 1'b1 || bus.done !== 1'b0) $display("FAIL ex2_busy busy %b done %b want 1 0", bus.busy, bus.done); else passed++;
        cyc();
        total++; if (bus.done !== 1'b1) $display("FAIL ex2_done_latency got %b want 1", bus.done); else passed++;
        total++; if (bus.cells !== 8'b0000_0100 || bus.gen_count !== 8'd1) $display("FAIL ex2_result cells %b gen %0d want 00000100 1", bus.cells, bus.gen_count); else passed++;
        cyc();
        run_expect(8'h31, 8'b0000_0001, 2'b00, 1'b1, 5, 1'b0);
        total++; if (bus.cells !== 8'b0000_0001 || bus.gen_count !== 8'd1 || bus.stable !== 1'b1)
            $display("FAIL ex3_stable cells %b gen %0d stable %b want 00000001 1 1", bus.cells, bus.gen_count, bus.stable);
        else passed++;
        run_expect(8'h08, 8'h00, 2'b01, 1'b0, 1, 1'b0);
        total++; if (bus.cells !== 8'h00) $display("FAIL ex4_zero_fill got %h want 00", bus.cells); else passed++;
        run_expect(8'h08, 8'h00, 2'b10, 1'b0, 1, 1'b0);
        total++; if (bus.cells !== 8'h80) $display("FAIL ex4_one_fill got %h want 80", bus.cells); else passed++;
        run_expect(8'h08, 8'h00, 2'b11, 1'b0, 1, 1'b0);
        total++; if (bus.cells !== 8'h00) $display("FAIL ex4_mode3_zero got %h want 00", bus.cells); else passed++;
    endtask

    task automatic test_hold_and_load();
        logic [W-1:0] g1, g3;
        g1 = model_next(8'h5A, 8'h6E, 2'b00);
        g3 = model_next(model_next(g1, 8'h6E, 2'b00), 8'h6E, 2'b00);
        do_load(8'h6E, 8'h5A);
        do_start(8'd3, 2'b00, 1'b0);
        cyc();
        bus.hold = 1'b1; bus.state_load = 1'b1; bus.state_in = 8'hFF;
        bus.rule_load = 1'b1; bus.rule_in = 8'h00; bus.start = 1'b1;
        cyc(); cyc();
        total++; if (bus.cells !== g1 || bus.gen_count !== 8'd1 || bus.busy !== 1'b1)
            $display("FAIL hold_freeze cells %b gen %0d busy %b want %b 1 1", bus.cells, bus.gen_count, bus.busy, g1);
        else passed++;
        bus.hold = 1'b0; bus.state_load = 1'b0; bus.rule_load = 1'b0; bus.start = 1'b0;
        cyc();
        total++; if (bus.done !== 1'b0) $display("FAIL hold_early_done got %b want 0", bus.done); else passed++;
        cyc();
        total++; if (bus.done !== 1'b1 || bus.gen_count !== 8'd3) $display("FAIL hold_done done %b gen %0d want 1 3", bus.done, bus.gen_count); else passed++;
        total++; if (bus.cells !== g3 || bus.rule !== 8'h6E) $display("FAIL run_load_ignored cells %b rule %h want %b 6e", bus.cells, bus.rule, g3); else passed++;
        cyc();
    endtask

    task automatic test_reset_midrun();
        do_load(8'h1E, 8'h10);
        do_start(8'd10, 2'b00, 1'b0);
        cyc(); cyc();
        total++; if (bus.gen_count !== 8'd2) $display("FAIL midrun_gen got %0d want 2", bus.gen_count); else passed++;
        rst = 1'b1; cyc(); rst = 1'b0;
        total++; if (bus.cells !== '0 || bus.rule !== 8'h31) $display("FAIL midrun_reset cells %h rule %h want 00 31", bus.cells, bus.rule); else passed++;
        total++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.gen_count !== '0) $display("FAIL midrun_flags busy %b done %b gen %0d want 0 0 0", bus.busy, bus.done, bus.gen_count); else passed++;
        cyc();
        total++; if (bus.done !== 1'b0) $display("FAIL midrun_no_done got %b want 0", bus.done); else passed++;
    endtask

    task automatic test_zero_gens_and_load_start();
        do_load(8'h96, 8'hC3);
        do_start(8'd0, 2'b00, 1'b0);
        total++; if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.cells !== 8'hC3 || bus.gen_count !== '0)
            $display("FAIL zero_gens done %b busy %b cells %h gen %0d want 1 0 c3 0", bus.done, bus.busy, bus.cells, bus.gen_count);
        else passed++;
        cyc();
        bus.state_load = 1'b1; bus.state_in = 8'h3C; bus.start = 1'b1; bus.num_gens = 8'd4;
        cyc();
        bus.state_load = 1'b0; bus.start = 1'b0;
        total++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.cells !== 8'h3C)
            $display("FAIL load_blocks_start busy %b done %b cells %h want 0 0 3c", bus.busy, bus.done, bus.cells);
        else passed++;
        cyc();
        total++; if (bus.busy !== 1'b0) $display("FAIL load_blocks_start_late busy %b want 0", bus.busy); else passed++;
    endtask

    task automatic test_random();
        for (int k = 0; k < 25; k++)
            run_expect(8'($urandom), W'($urandom), 2'($urandom), 1'($urandom), $urandom_range(1, 12), 1'b1);
    endtask

    initial begin
        rst = 1'b1;
        bus.rule_load = 1'b0; bus.rule_in = '0; bus.state_load = 1'b0; bus.state_in = '0;
        bus.boundary_mode = 2'b00; bus.stop_on_stable = 1'b0; bus.start = 1'b0;
        bus.num_gens = '0; bus.hold = 1'b0;
        test_reset();
        test_examples();
        test_hold_and_load();
        test_reset_midrun();
        test_zero_gens_and_load_start();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
